// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared clocking types and default bring-up timing constants
package clock_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABILIZE,
    REL_MEM,
    RUN,
    SOFT_RST
  } rst_seq_state_t;

  localparam int unsigned DEF_SYNC_STAGES      = 2;
  localparam int unsigned DEF_PLL_RST_CYCLES   = 8;
  localparam int unsigned DEF_LOCK_TIMEOUT     = 65536;
  localparam int unsigned DEF_STABLE_CYCLES    = 256;
  localparam int unsigned DEF_MEM_TO_SYS_DELAY = 16;
  localparam int unsigned DEF_SOFT_RST_CYCLES  = 32;

  localparam int unsigned RETRY_W = 4;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - lock/soft-reset inputs and reset outputs of the bring-up sequencer
interface reset_sequencer_if;
  import clock_pkg::*;

  logic               locked_i;
  logic               soft_rst_req_i;
  logic               pll_rst_o;
  logic               mem_rst_n_o;
  logic               sys_rst_n_o;
  logic               ready_o;
  logic [RETRY_W-1:0] retry_cnt_o;

  modport slave (
    input  locked_i,
    input  soft_rst_req_i,
    output pll_rst_o,
    output mem_rst_n_o,
    output sys_rst_n_o,
    output ready_o,
    output retry_cnt_o
  );

  modport master (
    output locked_i,
    output soft_rst_req_i,
    input  pll_rst_o,
    input  mem_rst_n_o,
    input  sys_rst_n_o,
    input  ready_o,
    input  retry_cnt_o
  );

endinterface

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - async-reset flop chain bringing a single asynchronous bit into clk_i
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL reset pulse, lock qualification and staged mem/sys reset release
module reset_sequencer
  import clock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int unsigned PLL_RST_CYCLES   = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES    = DEF_STABLE_CYCLES,
  parameter int unsigned MEM_TO_SYS_DELAY = DEF_MEM_TO_SYS_DELAY,
  parameter int unsigned SOFT_RST_CYCLES  = DEF_SOFT_RST_CYCLES
) (
  input logic              ext_clk_i,
  input logic              rst_n_i,
  reset_sequencer_if.slave bus
);

  localparam int unsigned MAX_T = max2(max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                            max2(STABLE_CYCLES, MEM_TO_SYS_DELAY)),
                                       SOFT_RST_CYCLES);
  localparam int CNT_W = $clog2(MAX_T) + 1;

  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] M2S_LAST    = CNT_W'(MEM_TO_SYS_DELAY - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST   = CNT_W'(SOFT_RST_CYCLES - 1);

  rst_seq_state_t     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, pll_rst_d;
  logic               mem_rst_n_q, mem_rst_n_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               ready_q, ready_d;
  logic               locked_s;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i   (ext_clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (bus.locked_i),
    .q_o     (locked_s)
  );

  // Lock loss is tested before soft reset and counter expiry in every locked state.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == PLL_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
        end
      end
      STABILIZE: begin
        if (!locked_s)                 state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = REL_MEM;
      end
      REL_MEM: begin
        if (!locked_s)              state_d = WAIT_LOCK;
        else if (cnt_q == M2S_LAST) state_d = RUN;
      end
      RUN: begin
        if (!locked_s)               state_d = WAIT_LOCK;
        else if (bus.soft_rst_req_i) state_d = SOFT_RST;
      end
      SOFT_RST: begin
        if (!locked_s)               state_d = WAIT_LOCK;
        else if (cnt_q == SOFT_LAST) state_d = RUN;
      end
      default: state_d = PLL_RST;
    endcase

    cnt_d = '0;
    if (state_d == state_q && state_q != RUN) cnt_d = cnt_q + CNT_W'(1);

    // Outputs are decoded from the next state so they change on the transition edge.
    pll_rst_d   = (state_d == PLL_RST);
    mem_rst_n_d = (state_d == REL_MEM) || (state_d == RUN) || (state_d == SOFT_RST);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
  end

  always_ff @(posedge ext_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      mem_rst_n_q <= 1'b0;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      mem_rst_n_q <= mem_rst_n_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.pll_rst_o   = pll_rst_q;
  assign bus.mem_rst_n_o = mem_rst_n_q;
  assign bus.sys_rst_n_o = sys_rst_n_q;
  assign bus.ready_o     = ready_q;
  assign bus.retry_cnt_o = retry_q;

endmodule
